// File: rtl/ifetch_unit_if.sv
// Instruction-bus types and the bus interface used by ifetch_unit.
//   ifetch_pkg      : ibus_req_t  {valid, addr}
//                     ibus_resp_t {addr_ok, data_ok, data}
//   ifetch_unit_if  : ireq  (request, driven by the fetch unit)
//                     iresp (response, driven by memory)
//   modports        : master = fetch unit side, slave = memory side
package ifetch_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

interface ifetch_unit_if
  import ifetch_pkg::*;
();
  ibus_req_t  ireq;
  ibus_resp_t iresp;

  modport master (output ireq, input iresp);
  modport slave  (input ireq, output iresp);
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch handshake stage between PC select and decode.
// Accepts one fetch address at a time, runs the address/data handshake on the
// instruction bus, holds the returned word with its PC and offers it to decode.
// Redirect flushes are honoured without breaking the bus protocol: a request
// already on the bus stays up until accepted and its response is discarded.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   pc_i, pc_valid_i      fetch address from PC select
//   pc_ready_o            address accepted when pc_valid_i && pc_ready_o
//   flush_i               redirect: drop held and in-flight instruction
//   bus (master)          ireq {valid, addr} out, iresp {addr_ok, data_ok, data} in
//   d_valid_o, d_ready_i  decode handshake
//   d_pc_o, d_instr_o     PC and word of the held instruction
// Optional feature (macro IFETCH_PERF_EN):
//   perf_fetched_o        instructions consumed by decode (wraps at 2^32)
//   perf_wait_o           cycles spent in REQ or WAIT (wraps at 2^32)
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          pc_i,
  input  logic                 pc_valid_i,
  output logic                 pc_ready_o,
  input  logic                 flush_i,
  ifetch_unit_if.master        bus,
  output logic                 d_valid_o,
  input  logic                 d_ready_i,
  output logic [31:0]          d_pc_o,
  output logic [31:0]          d_instr_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched_o,
  output logic [31:0]          perf_wait_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } state_t;

  state_t      state;
  logic        drop;
  logic        req_valid;
  logic [31:0] addr_q;
  logic [31:0] d_pc_q;
  logic [31:0] d_instr_q;
  logic        d_valid_q;
  logic        accept;

  // No new address while a dropped transaction is still draining off the bus.
  assign pc_ready_o = !drop && !flush_i &&
                      ((state == IDLE) || ((state == FULL) && d_ready_i));
  assign accept     = pc_valid_i && pc_ready_o;

  assign bus.ireq   = '{valid: req_valid, addr: addr_q};
  assign d_valid_o  = d_valid_q;
  assign d_pc_o     = d_pc_q;
  assign d_instr_o  = d_instr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      drop      <= 1'b0;
      req_valid <= 1'b0;
      addr_q    <= RESET_PC;
      d_pc_q    <= RESET_PC;
      d_instr_q <= 32'd0;
      d_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q    <= pc_i;
            req_valid <= 1'b1;
            state     <= REQ;
          end
        end

        REQ: begin
          // The request is held until addr_ok regardless of flush.
          if (bus.iresp.addr_ok) begin
            req_valid <= 1'b0;
            if (bus.iresp.data_ok) begin
              if (drop || flush_i) begin
                drop  <= 1'b0;
                state <= IDLE;
              end else begin
                d_instr_q <= bus.iresp.data;
                d_pc_q    <= addr_q;
                d_valid_q <= 1'b1;
                state     <= FULL;
              end
            end else begin
              if (flush_i) drop <= 1'b1;
              state <= WAIT;
            end
          end else if (flush_i) begin
            drop <= 1'b1;
          end
        end

        WAIT: begin
          if (bus.iresp.data_ok) begin
            // A flush arriving together with the data discards it as well.
            if (drop || flush_i) begin
              drop  <= 1'b0;
              state <= IDLE;
            end else begin
              d_instr_q <= bus.iresp.data;
              d_pc_q    <= addr_q;
              d_valid_q <= 1'b1;
              state     <= FULL;
            end
          end else if (flush_i) begin
            drop <= 1'b1;
          end
        end

        FULL: begin
          if (flush_i) begin
            d_valid_q <= 1'b0;
            state     <= IDLE;
          end else if (d_ready_i) begin
            d_valid_q <= 1'b0;
            if (accept) begin
              // Back-to-back: next request issues while the old word leaves.
              addr_q    <= pc_i;
              req_valid <= 1'b1;
              state     <= REQ;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  logic consume;
  assign consume = d_valid_q && d_ready_i && !flush_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_o <= 32'd0;
      perf_wait_o    <= 32'd0;
    end else begin
      if (consume) perf_fetched_o <= perf_fetched_o + 32'd1;
      if ((state == REQ) || (state == WAIT)) perf_wait_o <= perf_wait_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed scenarios followed by randomized traffic.
// A memory process answers bus requests with configurable or random latency;
// a monitor process keeps a queue of expected instructions (PC and memory word
// for every accepted address, removed on flush) and compares every word decode
// consumes, plus the request-hold rule of the bus.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        flush_i;
  logic        d_valid_o;
  logic        d_ready_i;
  logic [31:0] d_pc_o;
  logic [31:0] d_instr_o;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_wait_o;
`endif

  ifetch_unit_if bus ();

  ifetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_i       (pc_i),
    .pc_valid_i (pc_valid_i),
    .pc_ready_o (pc_ready_o),
    .flush_i    (flush_i),
    .bus        (bus),
    .d_valid_o  (d_valid_o),
    .d_ready_i  (d_ready_i),
    .d_pc_o     (d_pc_o),
    .d_instr_o  (d_instr_o)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched_o (perf_fetched_o),
    .perf_wait_o    (perf_wait_o)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents: word at address a. Chosen so 0xbfc00000 holds 0x24080001.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h9bc8_0001;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t expq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Memory model configuration (written by the stimulus process).
  int alat_cfg   = 0;
  int dlat_cfg   = 0;
  bit rand_lat   = 1'b0;
  bit inj_data_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Memory side of the bus: addr_ok after alat cycles of request, data_ok
  // dlat cycles after addr_ok (0 = same cycle).
  initial begin : memory
    bit          busy;
    bit          counting;
    int          acnt;
    int          dcnt;
    int          dl;
    logic [31:0] paddr;
    busy = 1'b0; counting = 1'b0; acnt = 0; dcnt = 0; dl = 0; paddr = '0;
    bus.iresp = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.iresp.addr_ok = 1'b0;
      bus.iresp.data_ok = 1'b0;
      bus.iresp.data    = 32'hdead_beef;
      if (reset) begin
        busy = 1'b0;
        counting = 1'b0;
      end else if (busy) begin
        dcnt--;
        if (dcnt <= 0) begin
          bus.iresp.data_ok = 1'b1;
          bus.iresp.data    = mem_fn(paddr);
          busy = 1'b0;
        end
      end else if (bus.ireq.valid) begin
        if (!counting) begin
          counting = 1'b1;
          acnt = rand_lat ? int'($urandom_range(0, 3)) : alat_cfg;
        end
        if (acnt == 0) begin
          bus.iresp.addr_ok = 1'b1;
          counting = 1'b0;
          dl = rand_lat ? int'($urandom_range(0, 3)) : dlat_cfg;
          if (dl == 0) begin
            bus.iresp.data_ok = 1'b1;
            bus.iresp.data    = mem_fn(bus.ireq.addr);
          end else begin
            busy  = 1'b1;
            dcnt  = dl;
            paddr = bus.ireq.addr;
          end
        end else begin
          acnt--;
        end
      end
      if (inj_data_ok) begin
        bus.iresp.data_ok = 1'b1;
        bus.iresp.data    = 32'h1234_5678;
      end
    end
  end

  task automatic monitor();
    logic        pv;
    logic [31:0] pa;
    logic        pok;
    exp_t        e;
    pv = 1'b0; pa = '0; pok = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        expq.delete();
        pv = 1'b0;
        continue;
      end
      if (pv && !pok) begin
        chk("ireq_valid_hold", {31'd0, bus.ireq.valid}, 32'd1);
        chk("ireq_addr_hold", bus.ireq.addr, pa);
      end
      pv  = bus.ireq.valid;
      pa  = bus.ireq.addr;
      pok = bus.iresp.addr_ok;
      if (d_valid_o && expq.size() == 0)
        chk("d_valid_spurious", {31'd0, d_valid_o}, 32'd0);
      if (d_valid_o && d_ready_i && !flush_i && expq.size() != 0) begin
        e = expq.pop_front();
        chk("sb_pc", d_pc_o, e.pc);
        chk("sb_instr", d_instr_o, e.instr);
      end
      if (flush_i) expq.delete();
      if (pc_valid_i && pc_ready_o) expq.push_back('{pc: pc_i, instr: mem_fn(pc_i)});
    end
  endtask

  initial begin : main
    logic [31:0] w0;
    w0 = '0;
    reset = 1'b1; pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0; d_ready_i = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_d_valid", {31'd0, d_valid_o}, 32'd0);
    chk("rst_ireq_valid", {31'd0, bus.ireq.valid}, 32'd0);
    chk("rst_ireq_addr", bus.ireq.addr, RESET_PC);
    chk("rst_d_pc", d_pc_o, RESET_PC);
    chk("rst_d_instr", d_instr_o, 32'd0);
    chk("rst_pc_ready", {31'd0, pc_ready_o}, 32'd1);
    cyc(); reset = 1'b0;

    // Minimum latency fetch
    alat_cfg = 0; dlat_cfg = 0;
    cyc(); pc_valid_i = 1'b1; pc_i = 32'hbfc0_0000;
    @(negedge clk); chk("t1_pc_ready", {31'd0, pc_ready_o}, 32'd1);
    cyc(); pc_valid_i = 1'b0;
    @(negedge clk);
    chk("t1_ireq_valid", {31'd0, bus.ireq.valid}, 32'd1);
    chk("t1_ireq_addr", bus.ireq.addr, 32'hbfc0_0000);
    cyc(); d_ready_i = 1'b1;
    @(negedge clk);
    chk("t1_d_valid", {31'd0, d_valid_o}, 32'd1);
    chk("t1_d_pc", d_pc_o, 32'hbfc0_0000);
    chk("t1_d_instr", d_instr_o, 32'h2408_0001);
    cyc(); d_ready_i = 1'b0;
    @(negedge clk); chk("t1_d_valid_drop", {31'd0, d_valid_o}, 32'd0);

    // Data three cycles after addr_ok
    dlat_cfg = 3;
    cyc(); pc_valid_i = 1'b1; pc_i = 32'hbfc0_0010;
`ifdef IFETCH_PERF_EN
    w0 = perf_wait_o;
`endif
    cyc(); pc_valid_i = 1'b0;
    @(negedge clk); chk("t2_ireq_valid_1", {31'd0, bus.ireq.valid}, 32'd1);
    cyc();
    @(negedge clk); chk("t2_ireq_valid_0", {31'd0, bus.ireq.valid}, 32'd0);
    cyc();
    cyc();
    @(negedge clk); chk("t2_d_valid_early", {31'd0, d_valid_o}, 32'd0);
    cyc(); d_ready_i = 1'b1;
    @(negedge clk);
    chk("t2_d_valid", {31'd0, d_valid_o}, 32'd1);
`ifdef IFETCH_PERF_EN
    chk("t2_perf_wait", perf_wait_o - w0, 32'd4);
`endif
    cyc(); d_ready_i = 1'b0;

    // Long addr_ok stall with flush pulse
    alat_cfg = 5; dlat_cfg = 1;
    cyc(); pc_valid_i = 1'b1; pc_i = 32'hbfc0_0020;
    for (int i = 1; i <= 6; i++) begin
      cyc(); pc_valid_i = 1'b0; flush_i = (i == 2);
      @(negedge clk);
      chk("t3_ireq_valid", {31'd0, bus.ireq.valid}, 32'd1);
      chk("t3_ireq_addr", bus.ireq.addr, 32'hbfc0_0020);
      chk("t3_d_valid", {31'd0, d_valid_o}, 32'd0);
    end
    cyc();
    @(negedge clk);
    chk("t3_ireq_valid_0", {31'd0, bus.ireq.valid}, 32'd0);
    chk("t3_pc_ready_drop", {31'd0, pc_ready_o}, 32'd0);
    cyc();
    @(negedge clk);
    chk("t3_pc_ready_back", {31'd0, pc_ready_o}, 32'd1);
    chk("t3_d_valid_end", {31'd0, d_valid_o}, 32'd0);

    // Decode stall then back-to-back
    alat_cfg = 0; dlat_cfg = 0;
    cyc(); pc_valid_i = 1'b1; pc_i = 32'hbfc0_0030; d_ready_i = 1'b0;
    cyc(); pc_valid_i = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_d_valid", {31'd0, d_valid_o}, 32'd1);
      chk("t4_pc_ready", {31'd0, pc_ready_o}, 32'd0);
      chk("t4_d_pc", d_pc_o, 32'hbfc0_0030);
      chk("t4_d_instr", d_instr_o, mem_fn(32'hbfc0_0030));
      cyc();
    end
    d_ready_i = 1'b1; pc_valid_i = 1'b1; pc_i = 32'hbfc0_0004;
    @(negedge clk); chk("t4_pc_ready_b2b", {31'd0, pc_ready_o}, 32'd1);
    cyc(); pc_valid_i = 1'b0;
    @(negedge clk);
    chk("t4_ireq_valid", {31'd0, bus.ireq.valid}, 32'd1);
    chk("t4_ireq_addr", bus.ireq.addr, 32'hbfc0_0004);
    cyc();
    @(negedge clk); chk("t4_d_valid_b2b", {31'd0, d_valid_o}, 32'd1);
    cyc(); d_ready_i = 1'b0;

    // Flush together with data_ok in WAIT
    dlat_cfg = 2;
    cyc(); pc_valid_i = 1'b1; pc_i = 32'hbfc0_0040;
    cyc(); pc_valid_i = 1'b0;
    cyc();
    cyc(); flush_i = 1'b1;
    cyc(); flush_i = 1'b0;
    @(negedge clk);
    chk("t5_d_valid", {31'd0, d_valid_o}, 32'd0);
    chk("t5_pc_ready", {31'd0, pc_ready_o}, 32'd1);
    chk("t5_d_pc", d_pc_o, 32'hbfc0_0004);
    chk("t5_d_instr", d_instr_o, mem_fn(32'hbfc0_0004));

    // Reset while in WAIT, stray data_ok afterwards
    dlat_cfg = 8;
    cyc(); pc_valid_i = 1'b1; pc_i = 32'hbfc0_0050;
    cyc(); pc_valid_i = 1'b0;
    cyc();
    cyc(); reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_ireq_valid", {31'd0, bus.ireq.valid}, 32'd0);
    chk("t6_rst_d_pc", d_pc_o, RESET_PC);
    cyc();
    cyc(); reset = 1'b0;
    cyc(); inj_data_ok = 1'b1;
    cyc(); inj_data_ok = 1'b0;
    @(negedge clk);
    chk("t6_d_valid", {31'd0, d_valid_o}, 32'd0);
    chk("t6_d_instr", d_instr_o, 32'd0);
    chk("t6_pc_ready", {31'd0, pc_ready_o}, 32'd1);
    cyc();
    @(negedge clk); chk("t6_d_valid_late", {31'd0, d_valid_o}, 32'd0);

    // Randomized traffic
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      pc_valid_i = ($urandom_range(0, 3) != 0);
      pc_i       = $urandom() & 32'hffff_fffc;
      d_ready_i  = ($urandom_range(0, 3) != 0);
      flush_i    = ($urandom_range(0, 19) == 0);
    end
    cyc(); pc_valid_i = 1'b0; flush_i = 1'b0; d_ready_i = 1'b1;
    for (int i = 0; i < 40 && expq.size() != 0; i++) cyc();
    @(negedge clk);
    chk("drain_empty", expq.size(), 32'd0);
    chk("drain_d_valid", {31'd0, d_valid_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch handshake stage sitting between the PC-select/fetch logic and decode. Accepts one fetch address at a time, drives the instruction bus (`ibus_req_t`/`ibus_resp_t`) through its address/data handshake, holds the returned instruction with its PC, and presents it to decode under a valid/ready handshake. Supports redirect flushes while a bus transaction is outstanding, without violating the bus protocol.

## Interface
Parameters:
- `RESET_PC`, 32'hbfc0_0000: value of `d_pc_o` and the internal address register after reset.

Ports:
- `clk` in 1: clock, all state updates on posedge.
- `reset` in 1: asynchronous, active-high reset.
- `pc_i` in 32: fetch address from PC select.
- `pc_valid_i` in 1: `pc_i` is valid.
- `pc_ready_o` out 1: address accepted this cycle when `pc_valid_i && pc_ready_o`.
- `flush_i` in 1: redirect; discard held and in-flight instruction.
- `ireq` out `ibus_req_t`: `valid`, `addr`.
- `iresp` in `ibus_resp_t`: `addr_ok`, `data_ok`, `data`.
- `d_valid_o` out 1: instruction available to decode.
- `d_ready_i` in 1: decode consumes when `d_valid_o && d_ready_i`.
- `d_pc_o` out 32: PC of held instruction.
- `d_instr_o` out 32: held instruction word.

## Operation
- States: IDLE, REQ, WAIT, FULL. Plus a 1-bit `drop` flag.
- IDLE: `pc_ready_o = !flush_i`. On accept, latch `pc_i` into `addr_q`, go REQ.
- REQ: `ireq.valid = 1`, `ireq.addr = addr_q`. Once raised, `ireq.valid` stays high with stable address until `addr_ok`, even under flush.
  - `addr_ok && data_ok` same cycle: go FULL (or IDLE if dropping).
  - `addr_ok` only: go WAIT.
- WAIT: `ireq.valid = 0`. On `data_ok`: if `drop`, clear `drop`, go IDLE; else latch `iresp.data` into `d_instr_o`, `addr_q` into `d_pc_o`, go FULL.
- FULL: `d_valid_o = 1`. `pc_ready_o = d_ready_i && !flush_i`.
  - Consume with new address accepted: latch `pc_i`, go REQ (back-to-back).
  - Consume with no address: go IDLE.
  - No consume: hold all outputs stable.
- Flush (`flush_i = 1`):
  - IDLE/FULL: go IDLE, `d_valid_o` drops next cycle; no address accepted that cycle.
  - REQ/WAIT: set `drop`; transaction completes on bus, response discarded, then IDLE. If flush coincides with `data_ok` in WAIT, the data is discarded.
  - `pc_ready_o` is low in every state while `drop` is set.
- `d_pc_o`/`d_instr_o` change only on a non-dropped `data_ok` capture.

## Timing
- Reset values: state IDLE, `drop` 0, `ireq.valid` 0, `ireq.addr`/`d_pc_o` = `RESET_PC`, `d_instr_o` 0, `d_valid_o` 0, `pc_ready_o` 1 (combinational from IDLE).
- `ireq` driven from registers only; `pc_ready_o` combinational from state, `flush_i`, `d_ready_i`.
- Address accepted at cycle t → `ireq.valid` high at t+1.
- With `addr_ok` and `data_ok` both at t+1: `d_valid_o` high at t+2. Minimum latency 2 cycles; peak throughput one instruction per 2 cycles.
- Reset asserted mid-transaction: state cleared immediately; a later stray `data_ok` in IDLE/REQ-before-`addr_ok` is ignored.

## Configuration
- `IFETCH_PERF_EN`: when defined, adds outputs `perf_fetched_o` (32) counting instructions consumed by decode, and `perf_wait_o` (32) counting cycles in REQ or WAIT. Both reset to 0 and wrap at 2^32. When undefined, ports and counters are absent; behaviour otherwise identical.

## Test plan
- Reset, `pc_i=0xbfc00000` valid, memory `addr_ok`+`data_ok` at first request cycle, `data=0x24080001` → `d_valid_o` at cycle 2 with `d_pc_o=0xbfc00000`, `d_instr_o=0x24080001`.
- `addr_ok` at cycle 1, `data_ok` 3 cycles later → `ireq.valid` high exactly 1 cycle, `d_valid_o` the cycle after `data_ok`; `perf_wait_o=4` with `IFETCH_PERF_EN`.
- `addr_ok` held low 5 cycles with `flush_i` pulse at cycle 2 → `ireq.valid`/`addr` stable until `addr_ok`, response discarded, `d_valid_o` never rises, `pc_ready_o` returns high after `data_ok`.
- FULL with `d_ready_i=0` for 4 cycles → outputs stable, `pc_ready_o=0`; then `d_ready_i=1` with `pc_i=0xbfc00004` → `ireq.valid` next cycle, back-to-back.
- `flush_i` simultaneous with `data_ok` in WAIT → data dropped, state IDLE, `d_pc_o` unchanged.
- `reset` asserted while in WAIT, then `data_ok` pulsed after release → ignored; `d_valid_o=0`, `d_instr_o=0`.
